line_burst_adaptor: RTL
=======================

# line_burst_adaptor

Converts the single 256-bit line transactions issued by the L1/L2 arbiter into 4-beat, 64-bit burst transactions on the physical memory port. Sits directly downstream of the arbiter, which sees it as a line-wide memory with a one-cycle response pulse. The adaptor buffers one full line in each direction, counts beats, and handles exactly one outstanding transaction at a time.

## Interface

Parameters
- BEATS, 4, beats per line; fixed, not overridable
- BEAT_W, 64, bits per beat

Ports
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset rst, synchronous, active-high
- addr_i  in  27  line address from arbiter
- read_i  in  1  line read request; level, held until resp_o
- write_i  in  1  line write request; level, held until resp_o
- line_i  in  256  write data line
- line_o  out  256  read data line; valid in the resp_o cycle of a read and held until the next read completes
- resp_o  out  1  one-cycle completion pulse
- mem_addr_o  out  32  {latched addr, 5'b0}
- mem_read_o  out  1  burst read active
- mem_write_o  out  1  burst write active
- mem_burst_o  out  64  current write beat
- mem_burst_i  in  64  read beat data
- mem_resp_i  in  1  beat strobe: one beat transferred this cycle

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE: if write_i, latch addr_i and line_i, clear beat count, go to WRITE. Else if read_i, latch addr_i, clear count, go to READ. write_i has priority if both are high; both high is illegal for requesters.
- READ: mem_read_o=1. On each mem_resp_i, store mem_burst_i into line bits [64*count +: 64] and increment count. Beat 0 is the lowest-addressed 8 bytes. The 4th beat (count==3 with mem_resp_i) moves to DONE.
- WRITE: mem_write_o=1, mem_burst_o=wbuf[64*count +: 64]. Each mem_resp_i advances count. The 4th beat moves to DONE.
- DONE: resp_o=1 for exactly this cycle, then IDLE unconditionally.
- mem_read_o, mem_write_o, resp_o and mem_burst_o are decoded from state and registers only, with no combinational path from any input.
- mem_resp_i in IDLE or DONE is ignored, and no beat is stored.
- Gaps between beats (mem_resp_i low) stall the count; there is no timeout.
- Count is 2 bits and never wraps within a transaction because the exit happens on the 4th beat.

## Timing

- Reset values: state IDLE, count 0, line_o 0, mem_addr_o 0, resp_o 0, mem_read_o 0, mem_write_o 0, mem_burst_o 0.
- Request sampled at posedge N → mem_read_o/mem_write_o high from cycle N+1.
- Beats on consecutive cycles starting at N+1: the 4th beat is in N+4, DONE/resp_o is in N+5, and IDLE is in N+6.
- Minimum request-to-resp_o latency: 5 cycles.
- The requester must drop read_i/write_i before the posedge ending the resp_o cycle. A request still high in IDLE starts a new transaction.
- rst mid-burst: the next cycle is IDLE with mem_read_o/mem_write_o low, partial beats are discarded, resp_o is not issued, and line_o is cleared.
- mem_addr_o is stable from the accept edge through DONE.

## Configuration

- LINE_ADAPTOR_PERF_EN defined: adds ports rd_count_o and wr_count_o (out, 32 bits each). These count transactions that complete (DONE reached) for reads and writes respectively. Both are cleared by rst and wrap at 2^32.
- LINE_ADAPTOR_PERF_EN undefined: no counter ports or logic. Functional behaviour is identical.

## Structure

- Shared package line_adaptor_pkg holds:
  - state enum
  - BEATS, BEAT_W, LINE_W=256
  - OFFSET_W=5
- No sub-module; a single flat module.

## Test plan

- Read to addr_i=27'h1: mem_addr_o=32'h20. Beats 64'hA0…A3 on consecutive cycles. resp_o fires 5 cycles after the request; line_o={A3,A2,A1,A0}.
- Write line 256'h3…_2…_1…_0 (beat k = 64'hk repeated): mem_burst_o shows beats 0,1,2,3 in order; mem_write_o drops after the 4th strobe; resp_o pulses once.
- Read with mem_resp_i gaps (beats in cycles 1,3,4,7): data is assembled correctly and resp_o comes in cycle 8.
- read_i and write_i both high: a write is performed and mem_read_o stays 0 throughout.
- rst asserted after 2 read beats: IDLE next cycle, no resp_o, line_o=0. A following read completes normally.
- With LINE_ADAPTOR_PERF_EN: 3 reads + 2 writes give rd_count_o=3, wr_count_o=2. A transaction aborted by rst is not counted.

Source files
------------

// File: rtl/line_adaptor_pkg.sv
// Shared types and sizes for the line-to-burst memory adaptor.
// Optional perf counters in the top are enabled by LINE_ADAPTOR_PERF_EN.
package line_adaptor_pkg;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Splits 256-bit line requests into 4 x 64-bit memory bursts.
// Define LINE_ADAPTOR_PERF_EN to add rd_count_o / wr_count_o.
module line_burst_adaptor
  import line_adaptor_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [26:0]   addr_i,
  input  logic          read_i,
  input  logic          write_i,
  input  logic [255:0]  line_i,
  output logic [255:0]  line_o,
  output logic          resp_o,
  output logic [31:0]   mem_addr_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [63:0]   mem_burst_o,
  input  logic [63:0]   mem_burst_i,
  input  logic          mem_resp_i
`ifdef LINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]   rd_count_o,
  output logic [31:0]   wr_count_o
`endif
);

  state_t              state, state_n;
  logic [1:0]          cnt;
  logic [26:0]         addr_q;
  logic [LINE_W-1:0]   wbuf;
  logic [LINE_W-1:0]   rbuf;
  logic [LINE_W-1:0]   rbuf_n;
  logic                last;

  assign last       = mem_resp_i && (cnt == 2'(BEATS - 1));
  assign mem_addr_o = {addr_q, {OFFSET_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    resp_o      = 1'b0;
    mem_burst_o = '0;
    unique case (state)
      IDLE: begin
        if (write_i)     state_n = WRITE;
        else if (read_i) state_n = READ;
      end
      READ: begin
        mem_read_o = 1'b1;
        if (last) state_n = DONE;
      end
      WRITE: begin
        mem_write_o = 1'b1;
        mem_burst_o = wbuf[{cnt, 6'd0} +: BEAT_W];
        if (last) state_n = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Beats land in rbuf; line_o is only updated once the line is whole.
  always_comb begin
    rbuf_n = rbuf;
    rbuf_n[{cnt, 6'd0} +: BEAT_W] = mem_burst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      wbuf   <= '0;
      rbuf   <= '0;
      line_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_i) begin
            addr_q <= addr_i;
            wbuf   <= line_i;
            cnt    <= '0;
          end else if (read_i) begin
            addr_q <= addr_i;
            cnt    <= '0;
          end
        end
        READ: begin
          if (mem_resp_i) begin
            rbuf <= rbuf_n;
            if (last) line_o <= rbuf_n;
            else      cnt    <= cnt + 2'd1;
          end
        end
        WRITE: begin
          if (mem_resp_i && !last) cnt <= cnt + 2'd1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

`ifdef LINE_ADAPTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (state == READ && last)  rd_count_o <= rd_count_o + 32'd1;
      if (state == WRITE && last) wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule
